// File: rtl/calc_pkg.sv
// Shared definitions for the four-function calculator: FSM states, pending-op codes,
// button bit positions and sign-magnitude / magnitude helpers.
package calc_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_READY = 3'd1,
    S_MUL   = 3'd2,
    S_DIV   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_t;

  // Bit positions in the packed button vector; higher index wins on a tie.
  localparam int B_CLR = 5;
  localparam int B_EQ  = 4;
  localparam int B_ADD = 3;
  localparam int B_SUB = 2;
  localparam int B_MUL = 1;
  localparam int B_DIV = 0;

  // Sign-magnitude of width w (MSB = sign) to two's complement; -0 maps to 0.
  function automatic logic signed [31:0] sm2tc(input logic [31:0] sm, input int w);
    logic [31:0] mag;
    mag = sm & ((32'd1 << (w - 1)) - 32'd1);
    return sm[w-1] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic [31:0] absval(input logic signed [31:0] v);
    return v[31] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative magnitude engine: W-step shift-add multiply or restoring divide, one step per clock.
// The first step runs on the start edge; done pulses in the cycle after the last step.
// CALC_REM_EN exposes the divider remainder as an output port.
module calc_muldiv_iter
  import calc_pkg::*;
#(
  parameter int W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   quotient
`ifdef CALC_REM_EN
  ,
  output logic [W-1:0]   remainder
`endif
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    hi_p0, src_hi, nxt_hi, add_sum, shifted;
  logic [W+1:0]  trial;
  logic [W-1:0]  lo_p0, m_p0, src_lo, src_m, nxt_lo;
  logic          div_p0, src_div;
  logic [CW-1:0] cnt;

  // Multiply: hi:lo = partial product : multiplier, shifted right.
  // Divide:   hi:lo = partial remainder : dividend/quotient, shifted left.
  always_comb begin
    src_hi  = start ? '0 : hi_p0;
    src_lo  = start ? (is_div ? a : b) : lo_p0;
    src_m   = start ? (is_div ? b : a) : m_p0;
    src_div = start ? is_div : div_p0;
    add_sum = src_hi + (src_lo[0] ? {1'b0, src_m} : '0);
    shifted = {src_hi[W-1:0], src_lo[W-1]};
    trial   = {1'b0, shifted} - {2'b00, src_m};
    if (src_div) begin
      if (!trial[W+1]) begin
        nxt_hi = trial[W:0];
        nxt_lo = {src_lo[W-2:0], 1'b1};
      end else begin
        nxt_hi = shifted;
        nxt_lo = {src_lo[W-2:0], 1'b0};
      end
    end else begin
      nxt_hi = {1'b0, add_sum[W:1]};
      nxt_lo = {add_sum[0], src_lo[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      cnt  <= CW'(W - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start || (cnt != '0)) begin
      hi_p0  <= nxt_hi;
      lo_p0  <= nxt_lo;
      m_p0   <= src_m;
      div_p0 <= src_div;
    end
  end

  assign product  = {hi_p0[W-1:0], lo_p0};
  assign quotient = lo_p0;
`ifdef CALC_REM_EN
  assign remainder = hi_p0[W-1:0];
`endif

endmodule

// File: rtl/four_func_calc_seq.sv
// W-bit accumulator calculator: edge-detected buttons, FSM, accumulator and sticky flags.
// Define CALC_REM_EN to add the signed Remainder output updated by each divide.
module four_func_calc_seq
  import calc_pkg::*;
#(
  parameter int W = 11
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Clear,
  input  logic                Equals,
  input  logic                Add,
  input  logic                Subtract,
  input  logic                Multiply,
  input  logic                Divide,
  input  logic [W-1:0]        Number,
  output logic signed [W-1:0] Result,
  output logic                Overflow,
  output logic                DivZero,
  output logic                Busy,
  output logic [2:0]          State
`ifdef CALC_REM_EN
  ,
  output logic signed [W-1:0] Remainder
`endif
);

  localparam logic [2*W-1:0] MAX_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] MIN_MAG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  // Magnitude fits the signed range, allowing -2^(W-1) only when negative.
  function automatic logic mag_ovf(input logic [2*W-1:0] mag, input logic neg);
    return (mag > MAX_POS) && !(neg && (mag == MIN_MAG));
  endfunction

  function automatic logic signed [W-1:0] apply_sign(input logic [2*W-1:0] mag, input logic neg);
    logic [W-1:0] low;
    low = mag[W-1:0];
    return neg ? -$signed(low) : $signed(low);
  endfunction

  logic [5:0] btn_raw, btn_p0, btn_p1, edg;
  state_t     state;
  op_t        op;
  logic       neg_p1;

  assign btn_raw = {Clear, Equals, Add, Subtract, Multiply, Divide};

  // Stage p0/p1: button registers; a rising edge is p0 high with p1 low.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
    end
  end

  assign edg = btn_p0 & ~btn_p1;

  logic signed [W-1:0] n_tc, sum, diff, fin_val;
  logic [W-1:0]        res_mag, n_mag, it_quo;
  logic [2*W-1:0]      it_prod, fin_mag;
  logic                add_ovf, sub_ovf, fin_ovf, idle, it_start, it_div, it_done;
`ifdef CALC_REM_EN
  logic [W-1:0]        it_rem;
`endif

  assign n_tc     = W'(sm2tc(32'(Number), W));
  assign res_mag  = W'(absval(32'(Result)));
  assign n_mag    = W'(absval(32'(n_tc)));
  assign sum      = Result + n_tc;
  assign diff     = Result - n_tc;
  assign add_ovf  = (Result[W-1] == n_tc[W-1]) && (sum[W-1] != Result[W-1]);
  assign sub_ovf  = (Result[W-1] != n_tc[W-1]) && (diff[W-1] != Result[W-1]);
  assign idle     = (state == S_INIT) || (state == S_READY);
  assign it_div   = (op == OP_DIV);
  assign it_start = idle && !edg[B_CLR] && edg[B_EQ] &&
                    ((op == OP_MUL) || (it_div && (n_mag != '0)));
  assign fin_mag  = (state == S_DIV) ? {{W{1'b0}}, it_quo} : it_prod;
  assign fin_ovf  = mag_ovf(fin_mag, neg_p1);
  assign fin_val  = apply_sign(fin_mag, neg_p1);

  calc_muldiv_iter #(.W(W)) u_iter (
    .clk      (Clock),
    .rst_n    (Resetn),
    .start    (it_start),
    .abort    (edg[B_CLR]),
    .is_div   (it_div),
    .a        (res_mag),
    .b        (n_mag),
    .done     (it_done),
    .product  (it_prod),
    .quotient (it_quo)
`ifdef CALC_REM_EN
    ,
    .remainder(it_rem)
`endif
  );

  // Stage p1: FSM, accumulator and flags, acting on the detected edges.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn || edg[B_CLR]) begin
      state    <= S_INIT;
      op       <= OP_LOAD;
      Result   <= '0;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
      Busy     <= 1'b0;
      neg_p1   <= 1'b0;
`ifdef CALC_REM_EN
      Remainder <= '0;
`endif
    end else begin
      case (state)
        S_INIT, S_READY: begin
          if (edg[B_EQ]) begin
            op    <= OP_LOAD;
            state <= S_READY;
            case (op)
              OP_LOAD: Result <= n_tc;
              OP_ADD: begin
                Result <= sum;
                if (add_ovf) begin
                  Overflow <= 1'b1;
                  state    <= S_ERR;
                end
              end
              OP_SUB: begin
                Result <= diff;
                if (sub_ovf) begin
                  Overflow <= 1'b1;
                  state    <= S_ERR;
                end
              end
              OP_MUL: begin
                state  <= S_MUL;
                Busy   <= 1'b1;
                neg_p1 <= Result[W-1] ^ n_tc[W-1];
              end
              OP_DIV: begin
                if (n_mag == '0) begin
                  DivZero  <= 1'b1;
                  Overflow <= 1'b1;
                  state    <= S_ERR;
                end else begin
                  state  <= S_DIV;
                  Busy   <= 1'b1;
                  neg_p1 <= Result[W-1] ^ n_tc[W-1];
                end
              end
              default: ;
            endcase
          end else if (edg[B_ADD]) begin
            op    <= OP_ADD;
            state <= S_READY;
          end else if (edg[B_SUB]) begin
            op    <= OP_SUB;
            state <= S_READY;
          end else if (edg[B_MUL]) begin
            op    <= OP_MUL;
            state <= S_READY;
          end else if (edg[B_DIV]) begin
            op    <= OP_DIV;
            state <= S_READY;
          end
        end
        S_MUL, S_DIV: begin
          if (it_done) begin
            Busy   <= 1'b0;
            Result <= fin_val;
`ifdef CALC_REM_EN
            // Remainder carries the dividend's sign; Result is still the dividend here.
            if (state == S_DIV) Remainder <= Result[W-1] ? -$signed(it_rem) : $signed(it_rem);
`endif
            if (fin_ovf) begin
              Overflow <= 1'b1;
              state    <= S_ERR;
            end else begin
              state <= S_READY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_four_func_calc_seq.sv
// Bench for four_func_calc_seq (W=11): directed scenarios plus random op chains
// checked against an integer-arithmetic reference model.
module tb_four_func_calc_seq;
  import calc_pkg::*;

  localparam int W = 11;
  localparam int K_CLR = 5, K_EQ = 4, K_ADD = 3, K_SUB = 2, K_MUL = 1, K_DIV = 0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [5:0]          btn;
  logic [W-1:0]        num;
  logic signed [W-1:0] result;
  logic                ovf, dz, busy;
  logic [2:0]          st;
`ifdef CALC_REM_EN
  logic signed [W-1:0] rem;
`endif

  four_func_calc_seq #(.W(W)) dut (
    .Clock    (clk),
    .Resetn   (rst_n),
    .Clear    (btn[K_CLR]),
    .Equals   (btn[K_EQ]),
    .Add      (btn[K_ADD]),
    .Subtract (btn[K_SUB]),
    .Multiply (btn[K_MUL]),
    .Divide   (btn[K_DIV]),
    .Number   (num),
    .Result   (result),
    .Overflow (ovf),
    .DivZero  (dz),
    .Busy     (busy),
    .State    (st)
`ifdef CALC_REM_EN
    ,
    .Remainder(rem)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 load, 1 add, 2 sub, 3 mul, 4 div
  int     m_res, m_rem, m_op;
  bit     m_ovf, m_dz;
  state_t m_st;

  function automatic int sm_val(input logic [W-1:0] sm);
    return sm[W-1] ? -int'(sm[W-2:0]) : int'(sm[W-2:0]);
  endfunction

  function automatic int wrapw(input longint v);
    longint m;
    m = ((v % 2048) + 2048) % 2048;
    return (m >= 1024) ? int'(m - 2048) : int'(m);
  endfunction

  task automatic model_reset();
    m_res = 0; m_rem = 0; m_op = 0; m_ovf = 0; m_dz = 0; m_st = S_INIT;
  endtask

  task automatic model_press(input int k, input logic [W-1:0] sm);
    int n;
    longint r;
    n = sm_val(sm);
    r = 0;
    if (k == K_CLR) begin
      model_reset();
    end else if (m_st != S_ERR) begin
      if (k == K_EQ) begin
        case (m_op)
          1: r = longint'(m_res) + n;
          2: r = longint'(m_res) - n;
          3: r = longint'(m_res) * n;
          4: if (n != 0) begin
               r = longint'(m_res / n);
               m_rem = m_res % n;
             end
          default: r = n;
        endcase
        if (m_op == 4 && n == 0) begin
          m_dz = 1; m_ovf = 1; m_st = S_ERR;
        end else begin
          m_res = wrapw(r);
          if (r > 1023 || r < -1024) begin
            m_ovf = 1; m_st = S_ERR;
          end else begin
            m_st = S_READY;
          end
        end
        m_op = 0;
      end else begin
        m_op = (k == K_ADD) ? 1 : (k == K_SUB) ? 2 : (k == K_MUL) ? 3 : 4;
        m_st = S_READY;
      end
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".overflow"}, ovf, m_ovf);
    chk({tag, ".divzero"}, dz, m_dz);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".state"}, st, m_st);
`ifdef CALC_REM_EN
    chk({tag, ".remainder"}, rem, m_rem);
`endif
  endtask

  // One-cycle button pulse, then wait (bounded) for any iteration to finish.
  task automatic press(input int k, input logic [W-1:0] n);
    int c;
    @(negedge clk);
    num = n;
    btn[k] = 1'b1;
    @(posedge clk); #1;
    btn[k] = 1'b0;
    @(posedge clk); #1;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    model_press(k, n);
  endtask

  // Raise Equals; returns just after the clock edge that samples it.
  task automatic raise_eq(input logic [W-1:0] n);
    @(negedge clk);
    num = n;
    btn[K_EQ] = 1'b1;
    @(posedge clk); #1;
    btn[K_EQ] = 1'b0;
  endtask

  int busy_cnt, done_at, opk;
  logic [W-1:0] rn;

  initial begin
    btn = '0;
    num = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset");

    // 1: chained adds
    press(K_EQ, 11'd1); chk("t1.busy_a", busy, 0);
    press(K_ADD, 11'd0);
    press(K_EQ, 11'd2); chk("t1.busy_b", busy, 0);
    press(K_ADD, 11'd0);
    press(K_EQ, 11'd3);
    check_all("t1");

    // 2: multiply timing
    press(K_CLR, 11'd0);
    press(K_EQ, 11'd2);
    press(K_MUL, 11'd0);
    raise_eq(11'd3);
    busy_cnt = 0;
    done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_cnt++;
      if (k == 6) chk("t2.held_during_busy", result, 2);
      if (busy === 1'b0 && done_at == 0 && result == 6) done_at = k;
    end
    chk("t2.busy_cycles", busy_cnt, 11);
    chk("t2.latency", done_at, 12);
    model_press(K_EQ, 11'd3);
    check_all("t2");

    // 3: signed divide with remainder
    press(K_EQ, 11'h407);
    press(K_DIV, 11'd0);
    press(K_EQ, 11'd2);
    chk("t3.quotient", result, -3);
    check_all("t3");

    // 4: divide by zero, error lock, clear
    press(K_EQ, 11'd5);
    press(K_DIV, 11'd0);
    press(K_EQ, 11'd0);
    check_all("t4.dz");
    press(K_ADD, 11'd0);
    press(K_EQ, 11'd3);
    chk("t4.locked", result, 5);
    check_all("t4.lock");
    press(K_CLR, 11'd0);
    check_all("t4.clear");
    press(K_EQ, 11'd5);
    press(K_DIV, 11'd0);
    press(K_EQ, 11'h400);
    check_all("t4.neg0");
    press(K_CLR, 11'd0);

    // 5: add and multiply overflow
    press(K_EQ, 11'd1023);
    press(K_ADD, 11'd0);
    press(K_EQ, 11'd1);
    chk("t5.wrap", result, -1024);
    check_all("t5.add");
    press(K_CLR, 11'd0);
    press(K_EQ, 11'd40);
    press(K_MUL, 11'd0);
    press(K_EQ, 11'd40);
    check_all("t5.mul");
    press(K_CLR, 11'd0);
    press(K_EQ, 11'h7FF);
    press(K_SUB, 11'd0);
    press(K_EQ, 11'd1);
    check_all("t5.min");
    press(K_DIV, 11'd0);
    press(K_EQ, 11'h401);
    check_all("t5.divovf");
    press(K_CLR, 11'd0);

    // Held Equals acts once; simultaneous Add+Divide picks Add
    press(K_EQ, 11'd5);
    press(K_ADD, 11'd0);
    @(negedge clk);
    num = 11'd1;
    btn[K_EQ] = 1'b1;
    repeat (5) @(posedge clk);
    #1 btn[K_EQ] = 1'b0;
    @(posedge clk); #1;
    model_press(K_EQ, 11'd1);
    check_all("hold");
    @(negedge clk);
    btn[K_ADD] = 1'b1;
    btn[K_DIV] = 1'b1;
    @(posedge clk); #1;
    btn[K_ADD] = 1'b0;
    btn[K_DIV] = 1'b0;
    @(posedge clk); #1;
    model_press(K_ADD, 11'd0);
    press(K_EQ, 11'd3);
    check_all("prio");

    // 6: clear mid-multiply, then a clean multiply
    press(K_CLR, 11'd0);
    press(K_EQ, 11'd2);
    press(K_MUL, 11'd0);
    raise_eq(11'd3);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    chk("t6.busy_before", busy, 1);
    btn[K_CLR] = 1'b1;
    @(posedge clk); #1;
    btn[K_CLR] = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all("t6.clear");
    press(K_EQ, 11'd3);
    press(K_MUL, 11'd0);
    press(K_EQ, 11'h404);
    check_all("t6.after");

    // 6b: async reset mid-divide
    press(K_EQ, 11'd100);
    press(K_DIV, 11'd0);
    raise_eq(11'd7);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    @(negedge clk);
    rst_n = 1'b1;

    // Random op chains
    for (int it = 0; it < 40; it++) begin
      if (it % 4 == 0) begin
        press(K_CLR, 11'd0);
        rn = W'($urandom);
        press(K_EQ, rn);
      end
      opk = $urandom_range(0, 3);
      rn = {1'($urandom), (opk == 2) ? 10'($urandom_range(0, 45)) : 10'($urandom)};
      press((opk == 0) ? K_ADD : (opk == 1) ? K_SUB : (opk == 2) ? K_MUL : K_DIV, 11'd0);
      press(K_EQ, rn);
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
